// File: rtl/button_event_detect.sv
// Front-panel button conditioning: synchronises and debounces the active-low
// power and reset buttons. It produces one-cycle press/release interrupt
// pulses per button and a long-press level for the power button.
module button_event_detect #(
  parameter int DEBOUNCE   = 1024,
  parameter int DB_W       = 11,
  parameter int LONG_PRESS = 131072,
  parameter int LP_W       = 18
) (
  input  logic       CLK32768,
  input  logic       ResetN,
  input  logic       PowerButtonN,
  input  logic       ResetButtonN,
  output logic [3:0] Interrupt,
  output logic       PowerLongPress,
  output logic       PowerPressed,
  output logic       ResetPressed
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    PRESSED   = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  // Last debounce count before a level change is accepted.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS);
  localparam logic [LP_W-1:0] LP_ZERO = {LP_W{1'b0}};
  localparam logic [LP_W-1:0] LP_ONE  = LP_W'(1);

  // Two-flop synchronisers; the pins idle high, so reset loads "released".
  logic pwr_meta_r;
  logic pwr_sync_r;
  logic rst_meta_r;
  logic rst_sync_r;

  // Power button FSM state
  state_t          pwr_state_r;
  logic [DB_W-1:0] pwr_db_r;
  logic [LP_W-1:0] pwr_lp_r;
  logic            pwr_press_r;
  logic            pwr_rel_r;
  logic            pwr_pressed_r;
  logic            pwr_long_r;

  // Reset button FSM state
  state_t          rst_state_r;
  logic [DB_W-1:0] rst_db_r;
  logic            rst_press_r;
  logic            rst_rel_r;
  logic            rst_pressed_r;

  // Bring both asynchronous button pins into the clock domain.
  always_ff @(posedge CLK32768 or negedge ResetN) begin
    if (!ResetN) begin
      pwr_meta_r <= 1'b1;
      pwr_sync_r <= 1'b1;
      rst_meta_r <= 1'b1;
      rst_sync_r <= 1'b1;
    end else begin
      pwr_meta_r <= PowerButtonN;
      pwr_sync_r <= pwr_meta_r;
      rst_meta_r <= ResetButtonN;
      rst_sync_r <= rst_meta_r;
    end
  end

  // Power button debounce FSM with long-press counter and registered pulses.
  always_ff @(posedge CLK32768 or negedge ResetN) begin
    if (!ResetN) begin
      pwr_state_r   <= IDLE;
      pwr_db_r      <= DB_ZERO;
      pwr_lp_r      <= LP_ZERO;
      pwr_press_r   <= 1'b0;
      pwr_rel_r     <= 1'b0;
      pwr_pressed_r <= 1'b0;
      pwr_long_r    <= 1'b0;
    end else begin
      pwr_press_r <= 1'b0;
      pwr_rel_r   <= 1'b0;
      case (pwr_state_r)
        IDLE: begin
          if (!pwr_sync_r) begin
            pwr_state_r <= PRESS_CHK;
            pwr_db_r    <= DB_ZERO;
          end
        end
        PRESS_CHK: begin
          if (pwr_sync_r) begin
            pwr_state_r <= IDLE;
          end else if (pwr_db_r == DB_LAST) begin
            pwr_state_r   <= PRESSED;
            pwr_press_r   <= 1'b1;
            pwr_pressed_r <= 1'b1;
            pwr_lp_r      <= LP_ZERO;
          end else begin
            pwr_db_r <= pwr_db_r + DB_ONE;
          end
        end
        PRESSED: begin
          // Saturating hold-time count; the level rises as the count hits the limit.
          if (pwr_lp_r != LP_MAX) begin
            pwr_lp_r <= pwr_lp_r + LP_ONE;
            if (pwr_lp_r == LP_MAX - LP_ONE) begin
              pwr_long_r <= 1'b1;
            end
          end
          if (pwr_sync_r) begin
            pwr_state_r <= REL_CHK;
            pwr_db_r    <= DB_ZERO;
          end
        end
        REL_CHK: begin
          // Still counted as held while the release is being confirmed.
          if (pwr_lp_r != LP_MAX) begin
            pwr_lp_r <= pwr_lp_r + LP_ONE;
            if (pwr_lp_r == LP_MAX - LP_ONE) begin
              pwr_long_r <= 1'b1;
            end
          end
          if (!pwr_sync_r) begin
            pwr_state_r <= PRESSED;
          end else if (pwr_db_r == DB_LAST) begin
            // A confirmed release drops the long-press level with the pulse.
            pwr_state_r   <= IDLE;
            pwr_rel_r     <= 1'b1;
            pwr_pressed_r <= 1'b0;
            pwr_long_r    <= 1'b0;
            pwr_lp_r      <= LP_ZERO;
          end else begin
            pwr_db_r <= pwr_db_r + DB_ONE;
          end
        end
        default: begin
          pwr_state_r   <= IDLE;
          pwr_db_r      <= DB_ZERO;
          pwr_lp_r      <= LP_ZERO;
          pwr_pressed_r <= 1'b0;
          pwr_long_r    <= 1'b0;
        end
      endcase
    end
  end

  // Reset button debounce FSM with registered pulses.
  always_ff @(posedge CLK32768 or negedge ResetN) begin
    if (!ResetN) begin
      rst_state_r   <= IDLE;
      rst_db_r      <= DB_ZERO;
      rst_press_r   <= 1'b0;
      rst_rel_r     <= 1'b0;
      rst_pressed_r <= 1'b0;
    end else begin
      rst_press_r <= 1'b0;
      rst_rel_r   <= 1'b0;
      case (rst_state_r)
        IDLE: begin
          if (!rst_sync_r) begin
            rst_state_r <= PRESS_CHK;
            rst_db_r    <= DB_ZERO;
          end
        end
        PRESS_CHK: begin
          if (rst_sync_r) begin
            rst_state_r <= IDLE;
          end else if (rst_db_r == DB_LAST) begin
            rst_state_r   <= PRESSED;
            rst_press_r   <= 1'b1;
            rst_pressed_r <= 1'b1;
          end else begin
            rst_db_r <= rst_db_r + DB_ONE;
          end
        end
        PRESSED: begin
          if (rst_sync_r) begin
            rst_state_r <= REL_CHK;
            rst_db_r    <= DB_ZERO;
          end
        end
        REL_CHK: begin
          if (!rst_sync_r) begin
            rst_state_r <= PRESSED;
          end else if (rst_db_r == DB_LAST) begin
            rst_state_r   <= IDLE;
            rst_rel_r     <= 1'b1;
            rst_pressed_r <= 1'b0;
          end else begin
            rst_db_r <= rst_db_r + DB_ONE;
          end
        end
        default: begin
          rst_state_r   <= IDLE;
          rst_db_r      <= DB_ZERO;
          rst_pressed_r <= 1'b0;
        end
      endcase
    end
  end

  assign Interrupt      = {pwr_rel_r, pwr_press_r, rst_rel_r, rst_press_r};
  assign PowerLongPress = pwr_long_r;
  assign PowerPressed   = pwr_pressed_r;
  assign ResetPressed   = rst_pressed_r;

endmodule

// File: tb/tb_button_event_detect.sv
// Bench for button_event_detect: directed scenarios plus randomized button
// activity, checked every cycle against a run-length debounce model.
module tb_button_event_detect;

  localparam int DEBOUNCE   = 4;
  localparam int DB_W       = 3;
  localparam int LONG_PRESS = 16;
  localparam int LP_W       = 5;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       pwr_n     = 1'b1;
  logic       rst_btn_n = 1'b1;
  logic [3:0] irq;
  logic       long_press;
  logic       pwr_pressed;
  logic       rst_pressed;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = reset button, 1 = power button.
  bit q_rst[$];
  bit q_pwr[$];
  bit dbn[2];
  int run[2];
  bit ev_p[2];
  bit ev_r[2];
  int held;

  button_event_detect #(
    .DEBOUNCE(DEBOUNCE), .DB_W(DB_W), .LONG_PRESS(LONG_PRESS), .LP_W(LP_W)
  ) dut (
    .CLK32768(clk),
    .ResetN(rst_n),
    .PowerButtonN(pwr_n),
    .ResetButtonN(rst_btn_n),
    .Interrupt(irq),
    .PowerLongPress(long_press),
    .PowerPressed(pwr_pressed),
    .ResetPressed(rst_pressed)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_rst = '{1'b1, 1'b1};
    q_pwr = '{1'b1, 1'b1};
    for (int b = 0; b < 2; b++) begin
      dbn[b] = 1'b0; run[b] = 0; ev_p[b] = 1'b0; ev_r[b] = 1'b0;
    end
    held = 0;
  endtask

  // A level change is accepted once DEBOUNCE+1 consecutive synchronised
  // samples disagree with the debounced level; pins reach the sync stage
  // two edges after they are sampled.
  task automatic model_edge(input bit pin_r, input bit pin_p);
    bit s_down[2];
    s_down[0] = !q_rst[0];
    s_down[1] = !q_pwr[0];
    void'(q_rst.pop_front());
    void'(q_pwr.pop_front());
    q_rst.push_back(pin_r);
    q_pwr.push_back(pin_p);
    for (int b = 0; b < 2; b++) begin
      ev_p[b] = 1'b0;
      ev_r[b] = 1'b0;
      if (s_down[b] != dbn[b]) begin
        run[b]++;
        if (run[b] == DEBOUNCE + 1) begin
          dbn[b] = s_down[b];
          run[b] = 0;
          if (dbn[b]) ev_p[b] = 1'b1;
          else        ev_r[b] = 1'b1;
        end
      end else begin
        run[b] = 0;
      end
    end
    if (ev_p[1])     held = 0;
    else if (dbn[1]) held++;
  endtask

  task automatic compare_outputs();
    check_val("irq", 32'(irq), 32'({ev_r[1], ev_p[1], ev_r[0], ev_p[0]}));
    check_val("pwr_pressed", 32'(pwr_pressed), 32'(dbn[1]));
    check_val("rst_pressed", 32'(rst_pressed), 32'(dbn[0]));
    check_val("long_press", 32'(long_press), 32'(dbn[1] && (held >= LONG_PRESS)));
  endtask

  // One clock edge: advance the model with the values the DUT sampled, then compare.
  task automatic tick();
    bit pr, pp, rn;
    @(posedge clk);
    pr = rst_btn_n;
    pp = pwr_n;
    rn = rst_n;
    #1;
    if (rn) model_edge(pr, pp);
    else    model_reset();
    compare_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_long", 32'(long_press), 32'd0);
    check_val("rst_pwr", 32'(pwr_pressed), 32'd0);
    check_val("rst_rst", 32'(rst_pressed), 32'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int pick_hold();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5)      return $urandom_range(1, 4);
    else if (r < 8) return $urandom_range(5, 12);
    else            return $urandom_range(17, 40);
  endfunction

  initial begin
    int first;
    int cnt;
    int e_press;
    int e_long;
    int hold_r;
    int hold_p;
    bit seen;
    bit prev_long;

    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // 1: reset button press, pulse expected 7 edges after first sample
    rst_btn_n = 1'b0;
    first = -1; cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (irq[0]) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    check_val("t1_edge", 32'(first), 32'd7);
    check_val("t1_count", 32'(cnt), 32'd1);
    check_val("t1_pressed", 32'(rst_pressed), 32'd1);
    rst_btn_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // 2: three-cycle glitch on power is ignored
    pwr_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); seen |= pwr_pressed | irq[2]; end
    pwr_n = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); seen |= pwr_pressed | irq[2]; end
    check_val("t2_no_event", 32'(seen), 32'd0);

    // 3: power held 30 cycles; long press 16 cycles after press pulse
    pwr_n = 1'b0;
    e_press = -1; e_long = -1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (irq[2] && e_press < 0) e_press = e;
      if (long_press && e_long < 0) e_long = e;
    end
    check_val("t3_long_delay", 32'(e_long - e_press), 32'd16);
    pwr_n = 1'b1;
    seen = 1'b0; prev_long = long_press;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (irq[3]) begin
        seen = 1'b1;
        check_val("t3_long_before", 32'(prev_long), 32'd1);
        check_val("t3_long_clear", 32'(long_press), 32'd0);
      end
      prev_long = long_press;
    end
    check_val("t3_release_seen", 32'(seen), 32'd1);

    // 4: both buttons pressed on the same edge pulse together
    pwr_n = 1'b0; rst_btn_n = 1'b0;
    seen = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (irq == 4'b0101) seen = 1'b1;
    end
    check_val("t4_together", 32'(seen), 32'd1);

    // 5: reset mid-operation, held buttons re-detected 7 edges after release
    do_reset();
    first = -1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (irq[0] && first < 0) first = e;
    end
    check_val("t5_edge", 32'(first), 32'd7);

    // 6: bounced power release gives one pulse, 7 edges after the final rise
    pwr_n = 1'b1; tick(); tick();
    pwr_n = 1'b0; tick();
    pwr_n = 1'b1;
    first = -1; cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (irq[3]) begin
        cnt++;
        if (first < 0) first = e;
      end
    end
    check_val("t6_edge", 32'(first), 32'd7);
    check_val("t6_count", 32'(cnt), 32'd1);

    // Randomized activity with occasional aligned changes and resets
    hold_r = pick_hold();
    hold_p = pick_hold();
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        hold_r--;
        hold_p--;
        if (hold_p <= 0) begin
          pwr_n  = ~pwr_n;
          hold_p = pick_hold();
          if ($urandom_range(0, 3) == 0) begin
            rst_btn_n = pwr_n;
            hold_r    = hold_p;
          end
        end
        if (hold_r <= 0) begin
          rst_btn_n = ~rst_btn_n;
          hold_r    = pick_hold();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
